// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle controller:
//   state_t      - FSM state encoding (also exported on the debug 'state' port)
//   OP_*         - recognised instruction opcodes (6-bit field values)
//   alu_op_t     - ALU operation select (00 add, 01 sub, 10 funct, 11 and)
//   alu_src_b_t  - ALU B-operand select (B reg, 4, sign-ext imm, imm<<2)
//   pc_source_t  - PC next-value select (ALU result, ALUOut, jump target)
//   ctrl_t       - bundle of every datapath control produced per state
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC      = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_IMM_EXEC  = 4'd10,
        ST_IMM_WB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SHIFT = 6'b110000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SL2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_source_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       instr_done;
        alu_src_b_t alu_src_b;
        pc_source_t pc_source;
        alu_op_t    alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// ---------------------------------------------------------------------------
// mc_out_decode
// Purely combinational control decode: maps the current FSM state, the
// latched opcode and the (effective) memory handshake to the datapath
// control bundle. Never looks at the live opcode.
//   state     in  state_t            current FSM state
//   op_q      in  [OPCODE_W-1:0]     opcode latched during DECODE
//   mem_ready in  1                  effective memory handshake
//   ctrl      out ctrl_t             datapath controls for this cycle
// ---------------------------------------------------------------------------
module mc_out_decode
    import mc_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_t              state,
    input  logic [OPCODE_W-1:0] op_q,
    input  logic                mem_ready,
    output ctrl_t               ctrl
);

    logic op_is_shift;
    logic op_is_andi;

    assign op_is_shift = (op_q == OPCODE_W'(OP_SHIFT));
    assign op_is_andi  = (op_q == OPCODE_W'(OP_ANDI));

    always_comb begin
        // NOTE: the whole bundle is cleared first so every path assigns every
        // field; without this, any field left untouched in a branch infers a latch.
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // IR load and PC+4 only happen on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (imm << 2).
                ctrl.alu_src_b = SRCB_IMM_SL2;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                // The store retires in the same cycle the memory accepts it.
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                // Shifts take the shift amount from the immediate field.
                ctrl.alu_src_b = op_is_shift ? SRCB_IMM : SRCB_REG;
            end
            ST_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = op_is_andi ? ALU_AND : ALU_ADD;
            end
            ST_IMM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a classic multicycle MIPS-style datapath. Holds the
// state and latched-opcode registers and the next-state logic; the per-state
// control decode lives in mc_out_decode.
//   clk           in   1         rising-edge clock
//   reset_n       in   1         synchronous active-low reset (also gates
//                                all control outputs to 0 while low)
//   opcode        in   OPCODE_W  instruction opcode from the IR
//   mem_ready     in   1         memory access completes this cycle
//   pc_write .. alu_src_a  out 1 datapath strobes/selects
//   alu_src_b     out  2         ALU B-operand select
//   pc_source     out  2         PC source select
//   alu_op        out  ALU_OP_W  ALU op (2-bit code zero-extended)
//   instr_done    out  1         pulse in the last state of an instruction
//   illegal_op    out  1         pulse in DECODE for an unknown opcode
//   state         out  4         current state, for debug
// ---------------------------------------------------------------------------
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 2,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [3:0]          state
);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                ready;
    logic                illegal_d;
    ctrl_t               ctrl_d;
    ctrl_t               ctrl_g;

    // With waits disabled every access is treated as single-cycle.
    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    // -----------------------------------------------------------------------
    // State and opcode registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!reset_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. DECODE is the only place the live opcode is used;
    // later states steer from op_q so the IR may change underneath them.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH:     state_d = ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (opcode == OPCODE_W'(OP_RTYPE) || opcode == OPCODE_W'(OP_SHIFT)) begin
                    state_d = ST_EXEC;
                end else if (opcode == OPCODE_W'(OP_ADDI) || opcode == OPCODE_W'(OP_ANDI)) begin
                    state_d = ST_IMM_EXEC;
                end else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) begin
                    state_d = ST_MEM_ADDR;
                end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                    state_d = ST_BRANCH;
                end else if (opcode == OPCODE_W'(OP_J)) begin
                    state_d = ST_JUMP;
                end else begin
                    state_d   = ST_FETCH;
                    illegal_d = 1'b1;
                end
            end
            ST_MEM_ADDR:  state_d = (op_q == OPCODE_W'(OP_LW)) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  state_d = ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: state_d = ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC:      state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_IMM_EXEC:  state_d = ST_IMM_WB;
            ST_IMM_WB:    state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode and reset gating
    // -----------------------------------------------------------------------
    mc_out_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_out_decode (
        .state     (state_q),
        .op_q      (op_q),
        .mem_ready (ready),
        .ctrl      (ctrl_d)
    );

    // Controls are forced quiet during reset, even before the first edge
    // has moved the state back to FETCH.
    assign ctrl_g = reset_n ? ctrl_d : '0;

    assign pc_write      = ctrl_g.pc_write;
    assign pc_write_cond = ctrl_g.pc_write_cond;
    assign i_or_d        = ctrl_g.i_or_d;
    assign ir_write      = ctrl_g.ir_write;
    assign mem_read      = ctrl_g.mem_read;
    assign mem_write     = ctrl_g.mem_write;
    assign mem_to_reg    = ctrl_g.mem_to_reg;
    assign reg_dst       = ctrl_g.reg_dst;
    assign reg_write     = ctrl_g.reg_write;
    assign alu_src_a     = ctrl_g.alu_src_a;
    assign alu_src_b     = ctrl_g.alu_src_b;
    assign pc_source     = ctrl_g.pc_source;
    assign alu_op        = ALU_OP_W'(ctrl_g.alu_op);
    assign instr_done    = ctrl_g.instr_done;
    assign illegal_op    = reset_n & illegal_d;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Cycle-by-cycle scoreboard bench. Each cycle the expected output vector
// {state, 12 strobes, alu_src_b, pc_source, alu_op[1:0]} is queued as the
// stimulus is driven and popped for comparison at the falling edge.
// Instance 'a' honours mem_ready; instance 'b' has waits disabled, mem_ready
// tied low and a 3-bit alu_op.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_SH   = 6'b110000;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_ANDI = 6'b001100;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    // strobe bit positions inside the 12-bit flag field
    localparam logic [11:0] F_PCW  = 12'h800;
    localparam logic [11:0] F_PCWC = 12'h400;
    localparam logic [11:0] F_IORD = 12'h200;
    localparam logic [11:0] F_IRW  = 12'h100;
    localparam logic [11:0] F_MR   = 12'h080;
    localparam logic [11:0] F_MW   = 12'h040;
    localparam logic [11:0] F_M2R  = 12'h020;
    localparam logic [11:0] F_RDST = 12'h010;
    localparam logic [11:0] F_RW   = 12'h008;
    localparam logic [11:0] F_ASA  = 12'h004;
    localparam logic [11:0] F_DONE = 12'h002;
    localparam logic [11:0] F_ILL  = 12'h001;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       reset_n_b = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic       pc_write_a, pc_write_cond_a, i_or_d_a, ir_write_a, mem_read_a, mem_write_a;
    logic       mem_to_reg_a, reg_dst_a, reg_write_a, alu_src_a_a, instr_done_a, illegal_op_a;
    logic [1:0] alu_src_b_a, pc_source_a, alu_op_a;
    logic [3:0] state_a;

    logic       pc_write_b, pc_write_cond_b, i_or_d_b, ir_write_b, mem_read_b, mem_write_b;
    logic       mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, instr_done_b, illegal_op_b;
    logic [1:0] alu_src_b_b, pc_source_b;
    logic [2:0] alu_op_b;
    logic [3:0] state_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_control #(.OPCODE_W(6), .ALU_OP_W(2), .MEM_WAIT_EN(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a), .i_or_d(i_or_d_a),
        .ir_write(ir_write_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .mem_to_reg(mem_to_reg_a), .reg_dst(reg_dst_a), .reg_write(reg_write_a),
        .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .pc_source(pc_source_a),
        .alu_op(alu_op_a), .instr_done(instr_done_a), .illegal_op(illegal_op_a),
        .state(state_a)
    );

    multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .MEM_WAIT_EN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .opcode(opcode), .mem_ready(1'b0),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .i_or_d(i_or_d_b),
        .ir_write(ir_write_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .pc_source(pc_source_b),
        .alu_op(alu_op_b), .instr_done(instr_done_b), .illegal_op(illegal_op_b),
        .state(state_b)
    );

    wire [21:0] obs_a = {state_a, pc_write_a, pc_write_cond_a, i_or_d_a, ir_write_a,
                         mem_read_a, mem_write_a, mem_to_reg_a, reg_dst_a, reg_write_a,
                         alu_src_a_a, instr_done_a, illegal_op_a,
                         alu_src_b_a, pc_source_a, alu_op_a};
    wire [21:0] obs_b = {state_b, pc_write_b, pc_write_cond_b, i_or_d_b, ir_write_b,
                         mem_read_b, mem_write_b, mem_to_reg_b, reg_dst_b, reg_write_b,
                         alu_src_a_b, instr_done_b, illegal_op_b,
                         alu_src_b_b, pc_source_b, alu_op_b[1:0]};

    function automatic logic [21:0] ev(input logic [3:0] st, input logic [11:0] f,
                                       input logic [1:0] asb, input logic [1:0] psrc,
                                       input logic [1:0] aop);
        return {st, f, asb, psrc, aop};
    endfunction

    task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expectation, compare at the falling edge.
    task automatic cyc(input bit sel_b, input bit rst_n, input bit rdy,
                       input logic [5:0] opc, input logic [21:0] e, input string tag);
        logic [21:0] want;
        @(posedge clk);
        #1;
        if (sel_b) reset_n_b = rst_n;
        else       reset_n   = rst_n;
        mem_ready = rdy;
        opcode    = opc;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        if (sel_b) begin
            check(tag, obs_b, want);
            check({tag, "_aluop_hi"}, {21'd0, alu_op_b[2]}, 22'd0);
        end else begin
            check(tag, obs_a, want);
        end
    endtask

    initial begin
        logic [21:0] e_fetch, e_fetch_wait, e_decode, e_zero;
        e_fetch      = ev(4'd0, F_MR | F_IRW | F_PCW, 2'b01, 2'b00, 2'b00);
        e_fetch_wait = ev(4'd0, F_MR, 2'b01, 2'b00, 2'b00);
        e_decode     = ev(4'd1, 12'h000, 2'b11, 2'b00, 2'b00);
        e_zero       = ev(4'd0, 12'h000, 2'b00, 2'b00, 2'b00);

        // reset: all quiet even with mem_ready high
        cyc(0, 0, 1, OPC_R, e_zero, "rst0");
        cyc(0, 0, 1, OPC_R, e_zero, "rst1");
        cyc(1, 0, 1, OPC_R, e_zero, "b_rst");

        // R-type: 0,1,6,7
        cyc(0, 1, 1, OPC_R, e_fetch, "r_fetch");
        cyc(0, 1, 1, OPC_R, e_decode, "r_decode");
        cyc(0, 1, 1, OPC_R, ev(4'd6, F_ASA, 2'b00, 2'b00, 2'b10), "r_exec");
        cyc(0, 1, 1, OPC_R, ev(4'd7, F_RDST | F_RW | F_DONE, 2'b00, 2'b00, 2'b00), "r_wb");

        // lw with a fetch wait and two memory wait cycles; opcode changes
        // after DECODE must not disturb the sequence
        cyc(0, 1, 0, OPC_LW, e_fetch_wait, "lw_fetch_wait");
        cyc(0, 1, 1, OPC_LW, e_fetch, "lw_fetch");
        cyc(0, 1, 1, OPC_LW, e_decode, "lw_decode");
        cyc(0, 1, 1, OPC_SW, ev(4'd2, F_ASA, 2'b10, 2'b00, 2'b00), "lw_addr");
        cyc(0, 1, 0, OPC_SW, ev(4'd3, F_MR | F_IORD, 2'b00, 2'b00, 2'b00), "lw_rd_w0");
        cyc(0, 1, 0, OPC_SW, ev(4'd3, F_MR | F_IORD, 2'b00, 2'b00, 2'b00), "lw_rd_w1");
        cyc(0, 1, 1, OPC_SW, ev(4'd3, F_MR | F_IORD, 2'b00, 2'b00, 2'b00), "lw_rd_go");
        cyc(0, 1, 1, OPC_SW, ev(4'd4, F_RW | F_M2R | F_DONE, 2'b00, 2'b00, 2'b00), "lw_wb");

        // sw with one wait cycle
        cyc(0, 1, 1, OPC_SW, e_fetch, "sw_fetch");
        cyc(0, 1, 1, OPC_SW, e_decode, "sw_decode");
        cyc(0, 1, 1, OPC_LW, ev(4'd2, F_ASA, 2'b10, 2'b00, 2'b00), "sw_addr");
        cyc(0, 1, 0, OPC_LW, ev(4'd5, F_MW | F_IORD, 2'b00, 2'b00, 2'b00), "sw_wr_wait");
        cyc(0, 1, 1, OPC_LW, ev(4'd5, F_MW | F_IORD | F_DONE, 2'b00, 2'b00, 2'b00), "sw_wr_go");

        // beq then j
        cyc(0, 1, 1, OPC_BEQ, e_fetch, "beq_fetch");
        cyc(0, 1, 1, OPC_BEQ, e_decode, "beq_decode");
        cyc(0, 1, 1, OPC_BEQ, ev(4'd8, F_ASA | F_PCWC | F_DONE, 2'b00, 2'b01, 2'b01), "beq_br");
        cyc(0, 1, 1, OPC_J, e_fetch, "j_fetch");
        cyc(0, 1, 1, OPC_J, e_decode, "j_decode");
        cyc(0, 1, 1, OPC_J, ev(4'd9, F_PCW | F_DONE, 2'b00, 2'b10, 2'b00), "j_jump");

        // addi, andi, shift
        cyc(0, 1, 1, OPC_ADDI, e_fetch, "addi_fetch");
        cyc(0, 1, 1, OPC_ADDI, e_decode, "addi_decode");
        cyc(0, 1, 1, OPC_ANDI, ev(4'd10, F_ASA, 2'b10, 2'b00, 2'b00), "addi_exec");
        cyc(0, 1, 1, OPC_ANDI, ev(4'd11, F_RW | F_DONE, 2'b00, 2'b00, 2'b00), "addi_wb");
        cyc(0, 1, 1, OPC_ANDI, e_fetch, "andi_fetch");
        cyc(0, 1, 1, OPC_ANDI, e_decode, "andi_decode");
        cyc(0, 1, 1, OPC_ADDI, ev(4'd10, F_ASA, 2'b10, 2'b00, 2'b11), "andi_exec");
        cyc(0, 1, 1, OPC_ADDI, ev(4'd11, F_RW | F_DONE, 2'b00, 2'b00, 2'b00), "andi_wb");
        cyc(0, 1, 1, OPC_SH, e_fetch, "sh_fetch");
        cyc(0, 1, 1, OPC_SH, e_decode, "sh_decode");
        cyc(0, 1, 1, OPC_R, ev(4'd6, F_ASA, 2'b10, 2'b00, 2'b10), "sh_exec");
        cyc(0, 1, 1, OPC_R, ev(4'd7, F_RDST | F_RW | F_DONE, 2'b00, 2'b00, 2'b00), "sh_wb");

        // illegal opcode: pulse in DECODE, back to FETCH
        cyc(0, 1, 1, OPC_BAD, e_fetch, "ill_fetch");
        cyc(0, 1, 1, OPC_BAD, ev(4'd1, F_ILL, 2'b11, 2'b00, 2'b00), "ill_decode");
        cyc(0, 1, 0, OPC_BAD, e_fetch_wait, "ill_refetch");

        // reset asserted mid-wait in MEM_WRITE
        cyc(0, 1, 1, OPC_SW, e_fetch, "rsw_fetch");
        cyc(0, 1, 1, OPC_SW, e_decode, "rsw_decode");
        cyc(0, 1, 0, OPC_SW, ev(4'd2, F_ASA, 2'b10, 2'b00, 2'b00), "rsw_addr");
        cyc(0, 1, 0, OPC_SW, ev(4'd5, F_MW | F_IORD, 2'b00, 2'b00, 2'b00), "rsw_wr_wait");
        cyc(0, 0, 1, OPC_SW, ev(4'd5, 12'h000, 2'b00, 2'b00, 2'b00), "rsw_rst_gate");
        cyc(0, 0, 1, OPC_SW, e_zero, "rsw_rst_state");
        cyc(0, 1, 1, OPC_R, e_fetch, "rsw_after");

        // waits disabled, mem_ready tied low: lw in 5 cycles, then andi
        cyc(1, 1, 0, OPC_LW, e_fetch, "b_lw_fetch");
        cyc(1, 1, 0, OPC_LW, e_decode, "b_lw_decode");
        cyc(1, 1, 0, OPC_LW, ev(4'd2, F_ASA, 2'b10, 2'b00, 2'b00), "b_lw_addr");
        cyc(1, 1, 0, OPC_LW, ev(4'd3, F_MR | F_IORD, 2'b00, 2'b00, 2'b00), "b_lw_rd");
        cyc(1, 1, 0, OPC_LW, ev(4'd4, F_RW | F_M2R | F_DONE, 2'b00, 2'b00, 2'b00), "b_lw_wb");
        cyc(1, 1, 0, OPC_ANDI, e_fetch, "b_andi_fetch");
        cyc(1, 1, 0, OPC_ANDI, e_decode, "b_andi_decode");
        cyc(1, 1, 0, OPC_ANDI, ev(4'd10, F_ASA, 2'b10, 2'b00, 2'b11), "b_andi_exec");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these parameters:
  OPCODE_W, 6, opcode field width.
  ALU_OP_W, 2, alu_op width.
  MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-002 The block SHALL have these ports:
  clk  in  1  sole clock, rising edge.
  reset_n  in  1  synchronous, active-low reset.
  opcode  in  OPCODE_W  instruction opcode, valid from the instruction register.
  mem_ready  in  1  memory handshake: access completes this cycle.
  pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1  datapath controls.
  alu_src_b  out  2  00 B reg; 01 const 4; 10 sign-ext imm; 11 imm<<2.
  pc_source  out  2  00 ALU result; 01 ALUOut; 10 jump target.
  alu_op  out  ALU_OP_W  00 add; 01 sub; 10 funct decode; 11 and.
  instr_done  out  1  one-cycle pulse in the final state of each instruction.
  illegal_op  out  1  one-cycle pulse on an unknown opcode.
  state  out  4  current FSM state, for debug.

Function
REQ-003 The FSM SHALL have these states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11.
REQ-004 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, and SHALL capture opcode into an internal op_q register.
REQ-006 DECODE SHALL branch on opcode: 000000 -> EXEC; 110000 -> EXEC; 001000/001100 -> IMM_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; any other opcode -> FETCH with illegal_op=1.
REQ-007 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_READ if op_q=100011, else to MEM_WRITE.
REQ-008 MEM_READ SHALL drive mem_read=1, i_or_d=1, and SHALL hold until mem_ready=1, then go to MEM_WB.
REQ-009 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1, then go to FETCH.
REQ-010 MEM_WRITE SHALL drive mem_write=1 and i_or_d=1 every cycle until mem_ready=1; in that cycle it SHALL assert instr_done and go to FETCH.
REQ-011 EXEC SHALL drive alu_src_a=1, alu_op=10, with alu_src_b=10 if op_q=110000 (shift) else 00, then go to R_WB.
REQ-012 R_WB SHALL drive reg_dst=1, reg_write=1, mem_to_reg=0, instr_done=1, then go to FETCH.
REQ-013 IMM_EXEC SHALL drive alu_src_a=1, alu_src_b=10, with alu_op=00 for addi and 11 for andi, then go to IMM_WB.
REQ-014 IMM_WB SHALL drive reg_dst=0, reg_write=1, mem_to_reg=0, instr_done=1, then go to FETCH.
REQ-015 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1, then go to FETCH.
REQ-016 JUMP SHALL drive pc_write=1, pc_source=10, instr_done=1, then go to FETCH.
REQ-017 Every output not listed for a state SHALL be 0 in that state; no output SHALL ever be X.
REQ-018 With zero wait cycles, cycle counts SHALL be: R/shift/addi/andi 4, lw 5, sw 4, beq 3, j 3.
REQ-019 If MEM_WAIT_EN=0, mem_ready SHALL be ignored and treated as 1.
REQ-020 Outputs SHALL be a combinational decode of state, op_q and mem_ready only; there SHALL be no combinational path from opcode except the DECODE-state transition and illegal_op.
REQ-021 An ALU_OP_W wider than 2 SHALL zero-extend the listed encodings.

Reset
REQ-022 A clock edge with reset_n=0 SHALL set state=FETCH and op_q=0, including mid-instruction and mid-wait.
REQ-023 While reset_n=0, all 1-bit outputs, alu_src_b, pc_source and alu_op SHALL be forced to 0.

Structure
REQ-024 A shared package mc_pkg SHALL hold the state encoding, opcode constants, alu_op, alu_src_b and pc_source encodings.
REQ-025 Output decode SHALL be a sub-module mc_out_decode (state, op_q, mem_ready -> controls); next-state logic and registers SHALL stay in multicycle_control.

Verification
REQ-026 Reset, then opcode=000000 with mem_ready=1 -> state sequence 0,1,6,7,0; reg_dst=1 and reg_write=1 in state 7; instr_done high exactly 1 cycle.
REQ-027 lw (100011) with mem_ready low 2 cycles in MEM_READ -> sequence 0,1,2,3,3,3,4,0; mem_read held 3 cycles; mem_to_reg=1 in state 4.
REQ-028 sw (101011) with 1 wait cycle -> mem_write high 2 cycles, reg_write never 1, instr_done on the completing cycle.
REQ-029 beq then j -> states 8 (alu_op=01, pc_write_cond=1, pc_source=01), then 9 (pc_write=1, pc_source=10).
REQ-030 Opcode 111111 -> illegal_op pulse in DECODE, next state FETCH, no write strobes asserted.
REQ-031 reset_n=0 during MEM_WRITE -> all outputs 0 immediately, state=0 after the edge; MEM_WAIT_EN=0 run of lw completes in 5 cycles with mem_ready tied to 0.
